// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe valid/data delay line.
package dff_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid flag plus a data register that only loads valid entries.
// Data reset is present only when DFF_PIPE_DATA_RESET_EN is defined.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic load;

    // Flush wins over enable; data is never touched by flush.
    assign load = en && !flush && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= in_valid;
        end
    end

`ifdef DFF_PIPE_DATA_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= RESET_VAL;
        end else if (load) begin
            data <= in_data;
        end
    end
`else
    logic unused_reset_val;
    assign unused_reset_val = ^RESET_VAL;

    always_ff @(posedge clk) begin
        if (load) begin
            data <= in_data;
        end
    end
`endif

endmodule

// File: rtl/dff_pipe.sv
// Fixed-latency valid/data delay line of DEPTH stages with stall, flush and occupancy count.
// Optional data reset: define DFF_PIPE_DATA_RESET_EN.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                dff_pipe_stage #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .en       (en),
                    .flush    (flush),
                    .in_valid (in_valid),
                    .in_data  (in_data),
                    .valid    (v[gi]),
                    .data     (d[gi])
                );
            end else begin : g_body
                dff_pipe_stage #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .en       (en),
                    .flush    (flush),
                    .in_valid (v[gi-1]),
                    .in_data  (d[gi-1]),
                    .valid    (v[gi]),
                    .data     (d[gi])
                );
            end
        end
    endgenerate

    // Incremental count: one may enter and one may leave on the same edge.
    always_comb begin
        occ_next = occ_reg;
        if (flush) begin
            occ_next = '0;
        end else if (en) begin
            occ_next = occ_reg + OCC_W'(in_valid) - OCC_W'(v[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_reg;

endmodule
